// File: rtl/ram_port_arbiter.sv
// Arbiter sharing one single-port RAM between the BIOS loader, CPU data and CPU fetch ports.
// BIOS has burst-capped fixed priority; the CPU ports alternate round-robin; read data returns next cycle.
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BIOS_BURST = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clk_en,
  input  logic                    i_booted,
  input  logic                    b_req,
  input  logic                    d_req,
  input  logic                    f_req,
  input  logic                    b_we,
  input  logic                    d_we,
  input  logic [DATA_WIDTH/8-1:0] b_be,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [ADDR_WIDTH-1:0]   f_addr,
  input  logic [DATA_WIDTH-1:0]   b_wdata,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic                    b_gnt,
  output logic                    d_gnt,
  output logic                    f_gnt,
  output logic                    b_rvalid,
  output logic                    d_rvalid,
  output logic                    f_rvalid,
  output logic [DATA_WIDTH-1:0]   b_rdata,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic [DATA_WIDTH-1:0]   f_rdata,
  output logic                    ram_en,
  output logic                    ram_we,
  output logic [DATA_WIDTH/8-1:0] ram_be,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  input  logic [DATA_WIDTH-1:0]   ram_rdata
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(BIOS_BURST);

  typedef enum logic [1:0] {OWN_NONE, OWN_BIOS, OWN_DATA, OWN_FETCH} owner_t;
  typedef enum logic {RR_DATA, RR_FETCH} rr_t;

  owner_t           rd_owner;
  owner_t           winner;
  rr_t              rr_ptr;
  logic [CNT_W-1:0] burst_cnt;
  logic             active;
  logic             b_el;
  logic             d_el;
  logic             f_el;
  logic             cpu_el;
  logic             rd_grant;

  // Handshake: a port's gnt is high in the same cycle its access is on ram_*;
  // the requester holds req and fields stable until it sees gnt. rvalid follows one cycle later.
  always_comb begin
    active = rst_n & clk_en;
    b_el   = active & b_req;
    d_el   = active & i_booted & d_req;
    f_el   = active & i_booted & f_req;
    cpu_el = d_el | f_el;

    winner = OWN_NONE;
    if (b_el && (!cpu_el || burst_cnt < BURST_MAX)) begin
      winner = OWN_BIOS;
    end else if (cpu_el) begin
      if (rr_ptr == RR_DATA) winner = d_el ? OWN_DATA : OWN_FETCH;
      else                   winner = f_el ? OWN_FETCH : OWN_DATA;
    end

    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    case (winner)
      OWN_BIOS: begin
        ram_en    = 1'b1;
        ram_we    = b_we;
        ram_be    = b_we ? b_be : '1;
        ram_addr  = b_addr;
        ram_wdata = b_wdata;
      end
      OWN_DATA: begin
        ram_en    = 1'b1;
        ram_we    = d_we;
        ram_be    = d_we ? d_be : '1;
        ram_addr  = d_addr;
        ram_wdata = d_wdata;
      end
      OWN_FETCH: begin
        ram_en    = 1'b1;
        ram_be    = '1;
        ram_addr  = f_addr;
      end
      default: ;
    endcase

    b_gnt    = (winner == OWN_BIOS);
    d_gnt    = (winner == OWN_DATA);
    f_gnt    = (winner == OWN_FETCH);
    rd_grant = ram_en & ~ram_we;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_owner  <= OWN_NONE;
      rr_ptr    <= RR_DATA;
      burst_cnt <= '0;
    end else begin
      rd_owner <= rd_grant ? winner : OWN_NONE;
      if (clk_en) begin
        if (winner == OWN_DATA)       rr_ptr <= RR_FETCH;
        else if (winner == OWN_FETCH) rr_ptr <= RR_DATA;

        if (winner == OWN_DATA || winner == OWN_FETCH || !b_req)
          burst_cnt <= '0;
        else if (winner == OWN_BIOS && cpu_el && burst_cnt < BURST_MAX)
          burst_cnt <= burst_cnt + 1'b1;
      end
    end
  end

  // Gating with rst_n drops a response whose reset arrives while it is outstanding.
  assign b_rvalid = rst_n & (rd_owner == OWN_BIOS);
  assign d_rvalid = rst_n & (rd_owner == OWN_DATA);
  assign f_rvalid = rst_n & (rd_owner == OWN_FETCH);
  assign b_rdata  = ram_rdata;
  assign d_rdata  = ram_rdata;
  assign f_rdata  = ram_rdata;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a small behavioural RAM behind the arbiter.
module tb_ram_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk;
  logic          rst_n;
  logic          clk_en;
  logic          i_booted;
  logic          b_req, d_req, f_req;
  logic          b_we, d_we;
  logic [BW-1:0] b_be, d_be;
  logic [AW-1:0] b_addr, d_addr, f_addr;
  logic [DW-1:0] b_wdata, d_wdata;
  logic          b_gnt, d_gnt, f_gnt;
  logic          b_rvalid, d_rvalid, f_rvalid;
  logic [DW-1:0] b_rdata, d_rdata, f_rdata;
  logic          ram_en, ram_we;
  logic [BW-1:0] ram_be;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [0:63];

  ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BIOS_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .i_booted(i_booted),
    .b_req(b_req), .d_req(d_req), .f_req(f_req),
    .b_we(b_we), .d_we(d_we), .b_be(b_be), .d_be(d_be),
    .b_addr(b_addr), .d_addr(d_addr), .f_addr(f_addr),
    .b_wdata(b_wdata), .d_wdata(d_wdata),
    .b_gnt(b_gnt), .d_gnt(d_gnt), .f_gnt(f_gnt),
    .b_rvalid(b_rvalid), .d_rvalid(d_rvalid), .f_rvalid(f_rvalid),
    .b_rdata(b_rdata), .d_rdata(d_rdata), .f_rdata(f_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_be(ram_be), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural single-port RAM: byte-enabled writes, one-cycle read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int k = 0; k < BW; k++)
          if (ram_be[k]) mem[ram_addr[7:2]][k*8 +: 8] <= ram_wdata[k*8 +: 8];
      end else begin
        ram_rdata <= mem[ram_addr[7:2]];
      end
    end
  end

  task automatic idle_inputs();
    b_req = 0; d_req = 0; f_req = 0;
    b_we = 0; d_we = 0; b_be = '0; d_be = '0;
    b_addr = '0; d_addr = '0; f_addr = '0;
    b_wdata = '0; d_wdata = '0;
  endtask

  // Each task starts just after a falling edge: drive, wait #1, compare, then advance.
  task automatic test_reset();
    rst_n = 0; clk_en = 1; i_booted = 1;
    idle_inputs();
    b_req = 1; d_req = 1; f_req = 1;
    #1;
    checks++;
    if ({b_gnt, d_gnt, f_gnt, ram_en, ram_we} !== 5'b0 || ram_addr !== '0) begin
      errors++;
      $display("FAIL reset_gnt: gnt=%b%b%b ram_en=%b ram_we=%b ram_addr=%h, required all 0",
               b_gnt, d_gnt, f_gnt, ram_en, ram_we, ram_addr);
    end
    @(negedge clk);
    idle_inputs();
    #1;
    checks++;
    if ({b_rvalid, d_rvalid, f_rvalid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_rvalid: rvalid=%b%b%b, required 000", b_rvalid, d_rvalid, f_rvalid);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_unbooted();
    i_booted = 0;
    d_req = 1; f_req = 1; d_addr = 32'h4; f_addr = 32'h8;
    b_req = 1; b_we = 0; b_addr = 32'h10;
    #1;
    checks++;
    if ({b_gnt, d_gnt, f_gnt} !== 3'b100 || ram_addr !== 32'h10 || ram_en !== 1'b1) begin
      errors++;
      $display("FAIL unbooted_gnt: gnt=%b%b%b ram_addr=%h ram_en=%b, required 100 / 00000010 / 1",
               b_gnt, d_gnt, f_gnt, ram_addr, ram_en);
    end
    @(negedge clk);
    b_req = 0;
    #1;
    checks++;
    if (b_rvalid !== 1'b1 || b_rdata !== 32'hC0DE_0004 || {d_gnt, f_gnt, ram_en} !== 3'b000) begin
      errors++;
      $display("FAIL unbooted_return: b_rvalid=%b b_rdata=%h d/f_gnt=%b%b ram_en=%b, required 1 c0de0004 00 0",
               b_rvalid, b_rdata, d_gnt, f_gnt, ram_en);
    end
    @(negedge clk);
    idle_inputs();
    i_booted = 1;
  endtask

  task automatic test_round_robin();
    d_req = 1; f_req = 1; d_we = 0; d_addr = 32'h4; f_addr = 32'h8;
    for (int i = 0; i < 7; i++) begin
      if (i == 6) begin d_req = 0; f_req = 0; end
      #1;
      if (i < 6) begin
        checks++;
        if (d_gnt !== (i % 2 == 0) || f_gnt !== (i % 2 == 1)) begin
          errors++;
          $display("FAIL rr_gnt[%0d]: d_gnt=%b f_gnt=%b, required %b %b",
                   i, d_gnt, f_gnt, i % 2 == 0, i % 2 == 1);
        end
      end
      if (i > 0) begin
        checks++;
        if (d_rvalid !== (i % 2 == 1) || f_rvalid !== (i % 2 == 0) || b_rvalid !== 1'b0 ||
            (i % 2 == 1 && d_rdata !== 32'hC0DE_0001) || (i % 2 == 0 && f_rdata !== 32'hC0DE_0002)) begin
          errors++;
          $display("FAIL rr_rvalid[%0d]: d_rvalid=%b f_rvalid=%b d_rdata=%h f_rdata=%h, required %b %b c0de0001/c0de0002",
                   i, d_rvalid, f_rvalid, d_rdata, f_rdata, i % 2 == 1, i % 2 == 0);
        end
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_bios_burst();
    logic [9:0] exp_b;
    exp_b = 10'b1111011110;
    b_req = 1; b_addr = 32'h10; d_req = 1; d_addr = 32'h4;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (b_gnt !== exp_b[9-i] || d_gnt !== !exp_b[9-i] || f_gnt !== 1'b0) begin
        errors++;
        $display("FAIL burst_gnt[%0d]: b_gnt=%b d_gnt=%b f_gnt=%b, required %b %b 0",
                 i, b_gnt, d_gnt, f_gnt, exp_b[9-i], !exp_b[9-i]);
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_write_read();
    b_req = 1; b_we = 1; b_be = 4'b0001; b_addr = 32'h20; b_wdata = 32'h0000_00A5;
    #1;
    checks++;
    if (b_gnt !== 1'b1 || ram_we !== 1'b1 || ram_be !== 4'b0001 || ram_wdata !== 32'hA5 || ram_addr !== 32'h20) begin
      errors++;
      $display("FAIL wr_drive: b_gnt=%b ram_we=%b ram_be=%b ram_wdata=%h ram_addr=%h, required 1 1 0001 000000a5 00000020",
               b_gnt, ram_we, ram_be, ram_wdata, ram_addr);
    end
    @(negedge clk);
    b_we = 0; b_be = 4'b0000;
    #1;
    checks++;
    if (b_gnt !== 1'b1 || ram_we !== 1'b0 || ram_be !== 4'b1111 || b_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL rd_drive: b_gnt=%b ram_we=%b ram_be=%b b_rvalid=%b, required 1 0 1111 0",
               b_gnt, ram_we, ram_be, b_rvalid);
    end
    @(negedge clk);
    b_req = 0;
    #1;
    checks++;
    if (b_rvalid !== 1'b1 || b_rdata !== 32'hC0DE_00A5) begin
      errors++;
      $display("FAIL wr_rd_data: b_rvalid=%b b_rdata=%h, required 1 c0de00a5", b_rvalid, b_rdata);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_clk_en();
    logic [2:0] exp_g [0:7];
    exp_g[0] = 3'b100; exp_g[1] = 3'b100; exp_g[2] = 3'b000; exp_g[3] = 3'b000;
    exp_g[4] = 3'b000; exp_g[5] = 3'b100; exp_g[6] = 3'b100; exp_g[7] = 3'b001;
    b_req = 1; b_addr = 32'h10; d_req = 1; d_addr = 32'h4; f_addr = 32'h8;
    for (int i = 0; i < 8; i++) begin
      clk_en = !(i >= 2 && i <= 4);
      f_req = (i >= 2);
      #1;
      checks++;
      if ({b_gnt, d_gnt, f_gnt} !== exp_g[i] || ram_en !== (exp_g[i] != 3'b000)) begin
        errors++;
        $display("FAIL clken_gnt[%0d]: gnt=%b%b%b ram_en=%b, required %b", i, b_gnt, d_gnt, f_gnt, ram_en, exp_g[i]);
      end
      if (i == 2 || i == 3) begin
        checks++;
        if (b_rvalid !== (i == 2) || (i == 2 && b_rdata !== 32'hC0DE_0004)) begin
          errors++;
          $display("FAIL clken_rvalid[%0d]: b_rvalid=%b b_rdata=%h, required %b c0de0004",
                   i, b_rvalid, b_rdata, i == 2);
        end
      end
      @(negedge clk);
    end
    idle_inputs();
    clk_en = 1;
  endtask

  task automatic test_reset_discard();
    d_req = 1; d_we = 0; d_addr = 32'h4;
    #1;
    checks++;
    if (d_gnt !== 1'b1) begin
      errors++;
      $display("FAIL discard_gnt: d_gnt=%b, required 1", d_gnt);
    end
    @(negedge clk);
    rst_n = 0; d_req = 0;
    #1;
    checks++;
    if (d_rvalid !== 1'b0 || ram_en !== 1'b0) begin
      errors++;
      $display("FAIL discard_rvalid: d_rvalid=%b ram_en=%b, required 0 0", d_rvalid, ram_en);
    end
    @(negedge clk);
    rst_n = 1; d_req = 1; f_req = 1; f_addr = 32'h8;
    #1;
    checks++;
    if (d_rvalid !== 1'b0 || d_gnt !== 1'b1 || f_gnt !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_rr: d_rvalid=%b d_gnt=%b f_gnt=%b, required 0 1 0", d_rvalid, d_gnt, f_gnt);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    for (int k = 0; k < 64; k++) mem[k] = 32'hC0DE_0000 | k;
    rst_n = 0; clk_en = 1; i_booted = 0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_unbooted();
    test_round_robin();
    test_bios_burst();
    test_write_read();
    test_clk_en();
    test_reset_discard();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
